// File: rtl/freq_meter_pkg.sv
// Shared types and defaults for the frequency meter.
// State encoding and parameter defaults live here.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOST = 2'd2
  } state_t;

  localparam int CNT_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 16'hFFFF;

endpackage

// File: rtl/freq_meter_sync_edge.sv
// Two-flop synchronizer, history flop and registered rise detect.
// level_o is the history flop so it lines up with rise_o.
module sync_edge (
  input  logic mclk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic s1;
  logic s2;
  logic hist;

  always_ff @(posedge mclk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      hist   <= 1'b0;
      rise_o <= 1'b0;
    end else begin
      s1     <= d_i;
      s2     <= s1;
      hist   <= s2;
      rise_o <= s2 & ~hist;
    end
  end

  assign level_o = hist;

endmodule

// File: rtl/freq_meter.sv
// Measures period and high time of sig_i in mclk cycles.
// Flags loss of input when no rising edge arrives within TIMEOUT.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             sig_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             lost_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] MAX = '1;

  state_t           state;
  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] hcnt;
  logic             level;
  logic             rise;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] c
  );
    return (c == MAX) ? c : c + ONE;
  endfunction

  sync_edge u_sync (
    .mclk    (mclk),
    .rst     (rst),
    .d_i     (sig_i),
    .level_o (level),
    .rise_o  (rise)
  );

  always_ff @(posedge mclk) begin
    if (rst) begin
      state    <= IDLE;
      pcnt     <= '0;
      hcnt     <= '0;
      period_o <= '0;
      high_o   <= '0;
      valid_o  <= 1'b0;
      lost_o   <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) begin
            pcnt  <= ONE;
            hcnt  <= ONE;
            state <= RUN;
          end
        end
        RUN: begin
          // a rise in the timeout cycle still counts as a measurement
          if (rise) begin
            period_o <= pcnt;
            high_o   <= hcnt;
            valid_o  <= 1'b1;
            pcnt     <= ONE;
            hcnt     <= ONE;
          end else if (pcnt == TO) begin
            state  <= LOST;
            lost_o <= 1'b1;
          end else begin
            pcnt <= sat_inc(pcnt);
            if (level) hcnt <= sat_inc(hcnt);
          end
        end
        LOST: begin
          if (rise) begin
            lost_o <= 1'b0;
            pcnt   <= ONE;
            hcnt   <= ONE;
            state  <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Randomized bench for freq_meter with a segment-level model.
// Two instances cover TIMEOUT=20 and the narrow CNT_W=4 case.
module tb_freq_meter;

  logic        mclk = 1'b0;
  logic        rst  = 1'b1;
  logic        sig_a = 1'b0;
  logic        sig_b = 1'b0;
  logic [15:0] period_a, high_a;
  logic        valid_a, lost_a;
  logic [3:0]  period_b, high_b;
  logic        valid_b, lost_b;

  typedef struct {
    int p;
    int h;
    int t;
  } meas_t;

  meas_t obs_a[$];
  meas_t obs_b[$];
  meas_t exp_q[$];
  int    cyc = 0;
  bit    lost_seen_b = 1'b0;
  int    checks = 0;
  int    errors = 0;

  always #5 mclk = ~mclk;

  freq_meter #(.CNT_W(16), .TIMEOUT(20)) u_a (
    .mclk     (mclk),
    .rst      (rst),
    .sig_i    (sig_a),
    .period_o (period_a),
    .high_o   (high_a),
    .valid_o  (valid_a),
    .lost_o   (lost_a)
  );

  freq_meter #(.CNT_W(4), .TIMEOUT(15)) u_b (
    .mclk     (mclk),
    .rst      (rst),
    .sig_i    (sig_b),
    .period_o (period_b),
    .high_o   (high_b),
    .valid_o  (valid_b),
    .lost_o   (lost_b)
  );

  always @(posedge mclk) cyc <= cyc + 1;

  always @(negedge mclk) begin
    if (valid_a) obs_a.push_back('{int'(period_a), int'(high_a), cyc});
    if (valid_b) obs_b.push_back('{int'(period_b), int'(high_b), cyc});
    if (lost_b) lost_seen_b = 1'b1;
  end

  // one square-wave segment: h cycles high then n-h low
  task automatic drive_seg(input bit b, input int n, input int h);
    for (int i = 0; i < n; i++) begin
      if (b) sig_b = (i < h);
      else   sig_a = (i < h);
      @(negedge mclk);
    end
  endtask

  // closing rise so the last full segment gets measured
  task automatic trail(input bit b);
    drive_seg(b, 8, 8);
    if (b) sig_b = 1'b0;
    else   sig_a = 1'b0;
    repeat (3) @(negedge mclk);
  endtask

  task automatic do_reset();
    sig_a = 1'b0;
    sig_b = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge mclk);
    rst = 1'b0;
    @(negedge mclk);
    obs_a.delete();
    obs_b.delete();
    lost_seen_b = 1'b0;
  endtask

  task automatic test_reset();
    sig_a = 1'b0;
    sig_b = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge mclk);
    checks++;
    if ({period_a, high_a, valid_a, lost_a} !== '0) begin
      errors++;
      $display("FAIL reset_a got p=%0d h=%0d v=%b l=%b want all 0",
               period_a, high_a, valid_a, lost_a);
    end
    checks++;
    if ({period_b, high_b, valid_b, lost_b} !== '0) begin
      errors++;
      $display("FAIL reset_b got p=%0d h=%0d v=%b l=%b want all 0",
               period_b, high_b, valid_b, lost_b);
    end
    rst = 1'b0;
    @(negedge mclk);
  endtask

  task automatic test_div16();
    do_reset();
    repeat (8) drive_seg(0, 16, 8);
    trail(0);
    checks++;
    if (obs_a.size() != 8) begin
      errors++;
      $display("FAIL div16_count got %0d want 8", obs_a.size());
    end
    for (int i = 0; i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i].p != 16 || obs_a[i].h != 8) begin
        errors++;
        $display("FAIL div16_meas[%0d] got %0d/%0d want 16/8",
                 i, obs_a[i].p, obs_a[i].h);
      end
      if (i > 0) begin
        checks++;
        if (obs_a[i].t - obs_a[i-1].t != 16) begin
          errors++;
          $display("FAIL div16_spacing[%0d] got %0d want 16",
                   i, obs_a[i].t - obs_a[i-1].t);
        end
      end
    end
  endtask

  task automatic test_10_3();
    do_reset();
    drive_seg(0, 10, 3);
    checks++;
    if (obs_a.size() != 0) begin
      errors++;
      $display("FAIL first_rise_valid got %0d want 0", obs_a.size());
    end
    drive_seg(0, 10, 3);
    drive_seg(0, 10, 3);
    trail(0);
    checks++;
    if (obs_a.size() != 3) begin
      errors++;
      $display("FAIL p10_count got %0d want 3", obs_a.size());
    end
    foreach (obs_a[i]) begin
      checks++;
      if (obs_a[i].p != 10 || obs_a[i].h != 3) begin
        errors++;
        $display("FAIL p10_meas[%0d] got %0d/%0d want 10/3",
                 i, obs_a[i].p, obs_a[i].h);
      end
    end
  endtask

  task automatic test_lost();
    int t_lost;
    bit seen;
    do_reset();
    drive_seg(0, 10, 3);
    sig_a = 1'b1;
    repeat (3) @(negedge mclk);
    sig_a = 1'b0;
    seen = 1'b0;
    t_lost = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge mclk);
      if (lost_a) begin
        seen = 1'b1;
        t_lost = cyc;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL lost_timeout got lost=0 want 1 within 60");
    end
    checks++;
    if (obs_a.size() != 1) begin
      errors++;
      $display("FAIL lost_pre_count got %0d want 1", obs_a.size());
    end else begin
      checks++;
      if (t_lost - obs_a[0].t != 20) begin
        errors++;
        $display("FAIL lost_delay got %0d want 20", t_lost - obs_a[0].t);
      end
    end
    repeat (10) @(negedge mclk);
    checks++;
    if (period_a !== 16'd10 || high_a !== 16'd3 || lost_a !== 1'b1) begin
      errors++;
      $display("FAIL lost_hold got p=%0d h=%0d l=%b want 10/3/1",
               period_a, high_a, lost_a);
    end
    drive_seg(0, 6, 4);
    checks++;
    if (lost_a !== 1'b0 || obs_a.size() != 1) begin
      errors++;
      $display("FAIL lost_clear got l=%b n=%0d want 0/1",
               lost_a, obs_a.size());
    end
    drive_seg(0, 4, 0);
    drive_seg(0, 12, 5);
    trail(0);
    exp_q = '{'{10, 3, 0}, '{10, 4, 0}, '{12, 5, 0}};
    checks++;
    if (obs_a.size() != 3) begin
      errors++;
      $display("FAIL lost_resume_count got %0d want 3", obs_a.size());
    end
    for (int i = 1; i < 3 && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i].p != exp_q[i].p || obs_a[i].h != exp_q[i].h) begin
        errors++;
        $display("FAIL lost_resume[%0d] got %0d/%0d want %0d/%0d", i,
                 obs_a[i].p, obs_a[i].h, exp_q[i].p, exp_q[i].h);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    drive_seg(0, 12, 5);
    drive_seg(0, 12, 5);
    drive_seg(0, 8, 5);
    checks++;
    if (obs_a.size() != 2 || period_a !== 16'd12) begin
      errors++;
      $display("FAIL pre_reset got n=%0d p=%0d want 2/12",
               obs_a.size(), period_a);
    end
    rst = 1'b1;
    @(negedge mclk);
    rst = 1'b0;
    checks++;
    if ({period_a, high_a, valid_a, lost_a} !== '0) begin
      errors++;
      $display("FAIL mid_reset got p=%0d h=%0d v=%b l=%b want all 0",
               period_a, high_a, valid_a, lost_a);
    end
    obs_a.delete();
    drive_seg(0, 9, 4);
    checks++;
    if (obs_a.size() != 0) begin
      errors++;
      $display("FAIL post_reset_arm got %0d want 0", obs_a.size());
    end
    drive_seg(0, 9, 4);
    trail(0);
    checks++;
    if (obs_a.size() != 2) begin
      errors++;
      $display("FAIL post_reset_count got %0d want 2", obs_a.size());
    end
    foreach (obs_a[i]) begin
      checks++;
      if (obs_a[i].p != 9 || obs_a[i].h != 4) begin
        errors++;
        $display("FAIL post_reset[%0d] got %0d/%0d want 9/4",
                 i, obs_a[i].p, obs_a[i].h);
      end
    end
  endtask

  task automatic test_narrow_timeout();
    do_reset();
    exp_q = '{'{14, 6, 0}, '{14, 6, 0}, '{15, 7, 0}, '{15, 1, 0}};
    foreach (exp_q[i]) drive_seg(1, exp_q[i].p, exp_q[i].h);
    trail(1);
    checks++;
    if (lost_seen_b) begin
      errors++;
      $display("FAIL narrow_lost got lost=1 want 0");
    end
    checks++;
    if (obs_b.size() != 4) begin
      errors++;
      $display("FAIL narrow_count got %0d want 4", obs_b.size());
    end
    for (int i = 0; i < 4 && i < obs_b.size(); i++) begin
      checks++;
      if (obs_b[i].p != exp_q[i].p || obs_b[i].h != exp_q[i].h) begin
        errors++;
        $display("FAIL narrow[%0d] got %0d/%0d want %0d/%0d", i,
                 obs_b[i].p, obs_b[i].h, exp_q[i].p, exp_q[i].h);
      end
    end
    repeat (25) @(negedge mclk);
    checks++;
    if (lost_b !== 1'b1 || period_b !== 4'd15 || high_b !== 4'd1) begin
      errors++;
      $display("FAIL narrow_gap got l=%b p=%0d h=%0d want 1/15/1",
               lost_b, period_b, high_b);
    end
  endtask

  task automatic test_random(input bit b);
    int n;
    int h;
    meas_t got[$];
    do_reset();
    exp_q.delete();
    for (int k = 0; k < 12; k++) begin
      n = b ? $urandom_range(15, 2) : $urandom_range(20, 2);
      h = $urandom_range(n - 1, 1);
      exp_q.push_back('{n, h, 0});
      drive_seg(b, n, h);
    end
    trail(b);
    got = b ? obs_b : obs_a;
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand%0d_count got %0d want %0d",
               b, got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i].p != exp_q[i].p || got[i].h != exp_q[i].h) begin
        errors++;
        $display("FAIL rand%0d[%0d] got %0d/%0d want %0d/%0d", b, i,
                 got[i].p, got[i].h, exp_q[i].p, exp_q[i].h);
      end
    end
  endtask

  initial begin
    @(negedge mclk);
    test_reset();
    test_div16();
    test_10_3();
    test_lost();
    test_mid_reset();
    test_narrow_timeout();
    test_random(0);
    test_random(1);
    test_random(0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
